// File: rtl/button_pkg.sv
// Shared defaults and repeat-FSM state type for the button conditioner.
package button_pkg;

  localparam int N_CH_DEF       = 4;
  localparam int STABLE_CYC_DEF = 5;
  localparam int REPEAT_DLY_DEF = 0;
  localparam int REPEAT_PER_DEF = 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REPEAT
  } rpt_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One input channel: two-flop synchroniser, counter debounce, edge pulses and hold-to-repeat.
//   state  | meaning
//   IDLE   | released, or repeat disabled
//   WAIT   | held, counting the initial repeat delay
//   REPEAT | held, emitting a pulse every REPEAT_PER cycles
module button_channel
  import button_pkg::*;
#(
  parameter int STABLE_CYC = STABLE_CYC_DEF,
  parameter int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int REPEAT_PER = REPEAT_PER_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic level,
  output logic press,
  output logic release_p,
  output logic rpt
);

  localparam int CW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam int HW = max2($clog2(max2(REPEAT_DLY, REPEAT_PER) + 1), 1);

  logic          s1, s2;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          level_nxt;
  logic          rise, fall;
  rpt_state_t    state, state_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic          rpt_nxt;

  always_comb begin
    level_nxt = level;
    cnt_nxt   = '0;
    if (s2 != level) begin
      if (cnt == CW'(STABLE_CYC - 1)) level_nxt = s2;
      else                            cnt_nxt   = cnt + CW'(1);
    end
  end

  assign rise = ~level & level_nxt;
  assign fall = level & ~level_nxt;

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    rpt_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (rise && (REPEAT_DLY != 0)) begin
          state_nxt = WAIT;
          hcnt_nxt  = HW'(1);
        end
      end
      WAIT: begin
        // A registered fall pre-empts any pulse due on the same edge.
        if (fall || !level) begin
          state_nxt = IDLE;
          hcnt_nxt  = '0;
        end else if (hcnt == HW'(REPEAT_DLY)) begin
          rpt_nxt   = 1'b1;
          state_nxt = REPEAT;
          hcnt_nxt  = HW'(1);
        end else begin
          hcnt_nxt = hcnt + HW'(1);
        end
      end
      REPEAT: begin
        if (fall || !level) begin
          state_nxt = IDLE;
          hcnt_nxt  = '0;
        end else if (hcnt == HW'(REPEAT_PER)) begin
          rpt_nxt  = 1'b1;
          hcnt_nxt = HW'(1);
        end else begin
          hcnt_nxt = hcnt + HW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        hcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      cnt       <= '0;
      level     <= 1'b0;
      press     <= 1'b0;
      release_p <= 1'b0;
      rpt       <= 1'b0;
      hcnt      <= '0;
      state     <= IDLE;
    end else begin
      s1        <= in;
      s2        <= s1;
      cnt       <= cnt_nxt;
      level     <= level_nxt;
      press     <= rise;
      release_p <= fall;
      rpt       <= rpt_nxt;
      hcnt      <= hcnt_nxt;
      state     <= state_nxt;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button front end: N_CH independent conditioned channels.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int STABLE_CYC = STABLE_CYC_DEF,
  parameter int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int REPEAT_PER = REPEAT_PER_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_p,
  output logic [N_CH-1:0] rpt
);

  if (STABLE_CYC < 1) begin : g_bad_stable
    $fatal(1, "button_conditioner: STABLE_CYC must be at least 1");
  end
  if (REPEAT_PER < 1) begin : g_bad_per
    $fatal(1, "button_conditioner: REPEAT_PER must be at least 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .STABLE_CYC(STABLE_CYC),
      .REPEAT_DLY(REPEAT_DLY),
      .REPEAT_PER(REPEAT_PER)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .in       (in[i]),
      .level    (level[i]),
      .press    (press[i]),
      .release_p(release_p[i]),
      .rpt      (rpt[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: STABLE_CYC=4, REPEAT_PER=3, one instance with REPEAT_DLY=10, one with repeat disabled.
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic [1:0] in_a, level_a, press_a, rel_a, rpt_a;
  logic [1:0] in_b, level_b, press_b, rel_b, rpt_b;
  int         checks;
  int         errors;

  button_conditioner #(.N_CH(2), .STABLE_CYC(4), .REPEAT_DLY(10), .REPEAT_PER(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in(in_a),
    .level(level_a), .press(press_a), .release_p(rel_a), .rpt(rpt_a)
  );

  button_conditioner #(.N_CH(2), .STABLE_CYC(4), .REPEAT_DLY(0), .REPEAT_PER(3)) u_dut_nr (
    .clk(clk), .rst_n(rst_n), .in(in_b),
    .level(level_b), .press(press_b), .release_p(rel_b), .rpt(rpt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge j of a scenario is the j-th call; inputs set before the call are seen at that edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_a  = 2'b00;
    in_b  = 2'b00;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({level_a, press_a, rel_a, rpt_a} !== 8'h00) begin
      errors++;
      $display("FAIL reset_a outputs=%h expected=00", {level_a, press_a, rel_a, rpt_a});
    end
    checks++;
    if ({level_b, press_b, rel_b, rpt_b} !== 8'h00) begin
      errors++;
      $display("FAIL reset_b outputs=%h expected=00", {level_b, press_b, rel_b, rpt_b});
    end
    // Reset held while the input is high must keep everything cleared.
    in_a  = 2'b11;
    rst_n = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      checks++;
      if ({level_a, press_a, rel_a, rpt_a} !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold j=%0d outputs=%h expected=00", j, {level_a, press_a, rel_a, rpt_a});
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clean_press;
    logic [1:0] e_lvl, e_prs, e_rpt;
    do_reset();
    in_a = 2'b01;
    for (int j = 0; j <= 24; j++) begin
      tick();
      e_lvl = {1'b0, j >= 5};
      e_prs = {1'b0, j == 5};
      e_rpt = {1'b0, (j == 15) || (j == 18) || (j == 21) || (j == 24)};
      checks++;
      if (level_a !== e_lvl || press_a !== e_prs || rpt_a !== e_rpt || rel_a !== 2'b00) begin
        errors++;
        $display("FAIL clean_press j=%0d lvl/prs/rpt/rel=%b/%b/%b/%b expected=%b/%b/%b/00",
                 j, level_a, press_a, rpt_a, rel_a, e_lvl, e_prs, e_rpt);
      end
    end
  endtask

  task automatic test_bounce;
    logic [13:0] pat;
    pat = 14'b00000000110111;   // bit j drives in[0] before edge j
    do_reset();
    for (int j = 0; j < 14; j++) begin
      in_a = {1'b0, pat[j]};
      tick();
      checks++;
      if (level_a !== 2'b00 || press_a !== 2'b00 || rpt_a !== 2'b00) begin
        errors++;
        $display("FAIL bounce j=%0d lvl/prs/rpt=%b/%b/%b expected=00/00/00",
                 j, level_a, press_a, rpt_a);
      end
    end
  endtask

  task automatic test_release;
    logic e_lvl, e_prs, e_rel, e_rpt;
    do_reset();
    // Press lands at edge 5; input drops after edge 11 so release lands at edge 17.
    for (int j = 0; j <= 30; j++) begin
      in_a = {1'b0, j <= 11};
      tick();
      e_lvl = (j >= 5) && (j <= 16);
      e_prs = (j == 5);
      e_rel = (j == 17);
      e_rpt = (j == 15);
      checks++;
      if ({level_a[0], press_a[0], rel_a[0], rpt_a[0]} !== {e_lvl, e_prs, e_rel, e_rpt}) begin
        errors++;
        $display("FAIL release j=%0d lvl,prs,rel,rpt=%b expected=%b",
                 j, {level_a[0], press_a[0], rel_a[0], rpt_a[0]}, {e_lvl, e_prs, e_rel, e_rpt});
      end
    end
  endtask

  task automatic test_independence;
    logic [1:0] e_prs, e_rpt;
    do_reset();
    for (int j = 0; j <= 24; j++) begin
      in_a = {j >= 2, 1'b1};
      tick();
      e_prs = {j == 7, j == 5};
      e_rpt = {(j == 17) || (j == 20) || (j == 23), (j == 15) || (j == 18) || (j == 21) || (j == 24)};
      checks++;
      if (press_a !== e_prs || rpt_a !== e_rpt) begin
        errors++;
        $display("FAIL independence j=%0d prs/rpt=%b/%b expected=%b/%b",
                 j, press_a, rpt_a, e_prs, e_rpt);
      end
    end
  endtask

  task automatic test_reset_mid_hold;
    logic e_lvl, e_prs;
    do_reset();
    in_a = 2'b01;
    for (int j = 0; j < 10; j++) tick();
    checks++;
    if (level_a !== 2'b01) begin
      errors++;
      $display("FAIL mid_hold_pre level=%b expected=01", level_a);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({level_a, press_a, rel_a, rpt_a} !== 8'h00) begin
      errors++;
      $display("FAIL mid_hold_reset outputs=%h expected=00", {level_a, press_a, rel_a, rpt_a});
    end
    for (int m = 1; m <= 9; m++) begin
      tick();
      e_lvl = (m >= 6);
      e_prs = (m == 6);
      checks++;
      if (level_a[0] !== e_lvl || press_a[0] !== e_prs || rel_a[0] !== 1'b0 || rpt_a[0] !== 1'b0) begin
        errors++;
        $display("FAIL mid_hold_repress m=%0d lvl/prs/rel/rpt=%b/%b/%b/%b expected=%b/%b/0/0",
                 m, level_a[0], press_a[0], rel_a[0], rpt_a[0], e_lvl, e_prs);
      end
    end
  endtask

  task automatic test_repeat_disabled;
    int n_prs, n_rpt, n_rel;
    n_prs = 0;
    n_rpt = 0;
    n_rel = 0;
    do_reset();
    for (int j = 0; j < 70; j++) begin
      in_b = {1'b0, j < 50};
      tick();
      n_prs += int'(press_b[0]);
      n_rpt += int'(rpt_b[0]) + int'(rpt_b[1]);
      n_rel += int'(rel_b[0]);
      if (j == 5) begin
        checks++;
        if (press_b[0] !== 1'b1) begin
          errors++;
          $display("FAIL nr_press_time press=%b expected=1", press_b[0]);
        end
      end
    end
    checks++;
    if (n_prs != 1) begin
      errors++;
      $display("FAIL nr_press_count got=%0d expected=1", n_prs);
    end
    checks++;
    if (n_rpt != 0) begin
      errors++;
      $display("FAIL nr_rpt_count got=%0d expected=0", n_rpt);
    end
    checks++;
    if (n_rel != 1) begin
      errors++;
      $display("FAIL nr_release_count got=%0d expected=1", n_rel);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    in_a   = 2'b00;
    in_b   = 2'b00;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_independence();
    test_reset_mid_hold();
    test_repeat_disabled();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised multi-channel front end for raw push-button and switch inputs. It provides the following per channel:
- two-flop synchronisation;
- counter-based debounce with a programmable stability window;
- single-cycle press and release pulses;
- optional hold-to-repeat pulses.

It sits between the board pins and all control FSMs, and it is the single source of edge events for user inputs.

## Interface
- `N_CH`, 4: number of independent input channels.
- `STABLE_CYC`, 5: consecutive synchronised cycles an input must differ from the debounced level before the level flips. Legal range is 1 or more.
- `REPEAT_DLY`, 0: cycles of continuous hold after the press before the first repeat pulse. A value of 0 disables repeat.
- `REPEAT_PER`, 1: cycles between successive repeat pulses while held. Legal range is 1 or more.
- `clk`, input, 1: sole clock. All logic is on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `in`, input, `N_CH`: raw asynchronous button levels. Active-high.
- `level`, output, `N_CH`: debounced level.
- `press`, output, `N_CH`: one-cycle pulse on each rising edge of `level`.
- `release_p`, output, `N_CH`: one-cycle pulse on each falling edge of `level`.
- `rpt`, output, `N_CH`: one-cycle auto-repeat pulse while held.

## Operation
- Channels are fully independent. Channel i uses only `in[i]`.
- **Synchroniser:** `in` → `s1` → `s2`.
- **Debounce counter `cnt`:** width is `$clog2(STABLE_CYC)`, minimum 1. Each edge:
  - if `s2 == level`, then `cnt <= 0`;
  - else if `cnt == STABLE_CYC-1`, then `level <= s2` and `cnt <= 0`;
  - else `cnt <= cnt+1`.
- Any mismatch streak shorter than `STABLE_CYC` is discarded. A glitch restarts the count from 0.
- **Pulse registers:** these are registered on the same edge that flips `level`.
  - `press <= ~level & level_nxt`
  - `release_p <= level & ~level_nxt`
  - Each pulse lasts exactly one cycle.
- **Repeat FSM, states IDLE, WAIT, REPEAT:**
  - IDLE: on the `level` rise, go to WAIT with `hcnt <= 1`. Stay in IDLE if `REPEAT_DLY == 0`.
  - WAIT: while `level`, `hcnt` increments. When `hcnt == REPEAT_DLY`, pulse `rpt`, go to REPEAT, and set `hcnt <= 1`.
  - REPEAT: while `level`, `hcnt` increments. When `hcnt == REPEAT_PER`, pulse `rpt` and set `hcnt <= 1`.
  - WAIT or REPEAT: if the `level` fall is registered, go to IDLE and clear `hcnt`. No `rpt` is issued on or after the release edge.
- `hcnt` width is `$clog2(max(REPEAT_DLY, REPEAT_PER)+1)`. It never wraps.
- `press` and `rpt` never coincide, because `REPEAT_DLY` is 1 or more when enabled. `rpt` and `release_p` never coincide.

## Timing
- **Reset value:** on `rst_n == 0` at an edge, the following are all cleared to 0: `s1`, `s2`, `cnt`, `level`, `press`, `release_p`, `rpt`, `hcnt`, and the FSM (to IDLE).
- **Latency:**
  - `in` changes before edge k. It is stable from then on.
  - `level`, and `press` or `release_p`, are high after edge k+1+`STABLE_CYC`.
- **Repeat timing:** with the press registered at edge E:
  - first `rpt` is high after edge E+`REPEAT_DLY`;
  - subsequent `rpt` pulses follow every `REPEAT_PER` edges.
- **Reset mid-press:** all state is lost. If `in` is still high, a fresh `press` occurs `STABLE_CYC`+2 edges after `rst_n` rises. This is required behaviour.
- **Reset and events:** reset dominates every simultaneous event. No output pulse is produced on the reset edge.
- **`STABLE_CYC == 1`:** `level` follows `s2` with one cycle delay. Every `s2` change then produces a pulse.

## Structure
- Package `button_pkg` holds:
  - the default parameter constants;
  - the repeat-FSM state enum `rpt_state_t` (IDLE, WAIT, REPEAT).
- Sub-module `button_channel` implements one channel: synchroniser, debounce, pulses and repeat FSM.
- The top level, `button_conditioner`, is a generate loop instantiating `N_CH` copies of `button_channel`.
- Parameter legality is checked with elaboration-time assertions:
  - `STABLE_CYC` of 1 or more;
  - `REPEAT_PER` of 1 or more.

## Test plan
Configuration for all scenarios: `N_CH`=2, `STABLE_CYC`=4, `REPEAT_DLY`=10, `REPEAT_PER`=3.

- **Clean press:** `in[0]` rises before edge 0 and stays high.
  - `level[0]` and `press[0]` are high after edge 5.
  - `press[0]` is low after edge 6.
  - `rpt[0]` pulses after edges 15, 18 and 21.
  - `in[1]` outputs stay 0 throughout.
- **Bounce:** `in[0]` toggles high 3 cycles, low 1, high 2, low.
  - `level`, `press` and `rpt` never assert.
- **Release:** press held for 12 cycles past `press`, then `in[0]` falls.
  - Exactly one `rpt` pulse, at `press`+10, is issued.
  - `release_p[0]` pulses 6 edges after the fall.
  - No `rpt` is issued afterwards.
- **Independence:** `in[0]` and `in[1]` rise 2 cycles apart.
  - The `press` pulses are 2 cycles apart.
  - The `rpt` streams are offset by 2 cycles.
- **Reset mid-hold:** hold `in[0]` high, with `level` already 1, and pulse `rst_n` low for 1 edge.
  - All outputs are 0 after the reset edge.
  - A new `press[0]` occurs 6 edges after `rst_n` returns high.
- **Repeat disabled:** with `REPEAT_DLY`=0, hold for 50 cycles.
  - Exactly one `press`, zero `rpt`, and one `release_p`.
